// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run controller.
//   sw_state_e : run/pause/split sequencer states
//   digit_t    : one BCD display digit
//   count_t    : packed M:SS digit triple
package stopwatch_pkg;

   localparam int DIGIT_W = 4;

   typedef logic [DIGIT_W-1:0] digit_t;

   localparam digit_t S0_MAX = 4'd9;
   localparam digit_t S1_MAX = 4'd5;
   localparam digit_t M0_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      SPLIT  = 2'd2,
      PAUSED = 2'd3
   } sw_state_e;

   typedef struct packed {
      digit_t m0;
      digit_t s1;
      digit_t s0;
   } count_t;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button-in / display-out bundle between the board and the stopwatch controller.
//   start_stop, lap, clear : raw button levels
//   disp_m0/s1/s0          : displayed M:SS digits
//   running, split         : sequencer status
//   tick, wrap             : one-cycle count advance / rollover pulses
// master = board / display side, slave = controller.
interface stopwatch_ctrl_if;
   import stopwatch_pkg::*;

   logic   start_stop;
   logic   lap;
   logic   clear;
   digit_t disp_m0;
   digit_t disp_s1;
   digit_t disp_s0;
   logic   running;
   logic   split;
   logic   tick;
   logic   wrap;

   modport master (
      output start_stop, lap, clear,
      input  disp_m0, disp_s1, disp_s0, running, split, tick, wrap
   );

   modport slave (
      input  start_stop, lap, clear,
      output disp_m0, disp_s1, disp_s0, running, split, tick, wrap
   );

endinterface

// File: rtl/btn_edge.sv
// Rising-edge detector for one raw button level.
//   clk   : system clock, sampled on the falling edge
//   reset : asynchronous active-low reset
//   btn   : raw button level
//   rise  : high while btn is 1 and the previous sample was 0
// prev resets to 0, so a button already held at reset release yields one event
// on the first edge.
module btn_edge (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic rise
);

   logic prev;

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) prev <= 1'b0;
      else        prev <= btn;
   end

   assign rise = btn & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run controller: button events -> run/pause/split sequencer,
// count-tick prescaler and cascaded M:SS digit counter with lap freeze.
//   clk   : system clock, all state updates on the falling edge
//   reset : asynchronous active-low reset
//   bus   : buttons in, display digits and status pulses out
//
// state  | meaning
// IDLE   | stopped at 0:00, waiting for start
// RUN    | counting, display live
// SPLIT  | counting, display frozen on the lap register
// PAUSED | counting halted, prescaler phase held
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 4
) (
   input  logic             clk,
   input  logic             reset,
   stopwatch_ctrl_if.slave  bus
);

   localparam int              PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);

   logic ev_ss;
   logic ev_lap;
   logic ev_clr;

   btn_edge u_edge_ss  (.clk(clk), .reset(reset), .btn(bus.start_stop), .rise(ev_ss));
   btn_edge u_edge_lap (.clk(clk), .reset(reset), .btn(bus.lap),        .rise(ev_lap));
   btn_edge u_edge_clr (.clk(clk), .reset(reset), .btn(bus.clear),      .rise(ev_clr));

   sw_state_e state;
   sw_state_e state_nxt;

   logic running;
   logic split_st;
   logic capture;
   logic zero_all;

   logic [PW-1:0] presc;
   count_t        cnt;
   count_t        cnt_inc;
   count_t        lap_q;
   count_t        disp;
   logic          advance;
   logic          at_max;
   logic          tick_q;
   logic          wrap_q;

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Each branch lists only the events legal in that state, highest priority
   // first, so an illegal higher-priority event never masks a legal one.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (ev_ss) state_nxt = RUN;
         end
         RUN: begin
            if      (ev_ss)  state_nxt = PAUSED;
            else if (ev_lap) state_nxt = SPLIT;
         end
         SPLIT: begin
            if      (ev_ss)  state_nxt = PAUSED;
            else if (ev_lap) state_nxt = RUN;
         end
         PAUSED: begin
            if      (ev_clr) state_nxt = IDLE;
            else if (ev_ss)  state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      running  = (state == RUN) || (state == SPLIT);
      split_st = (state == SPLIT);
      capture  = (state == RUN)    && (state_nxt == SPLIT);
      zero_all = (state == PAUSED) && (state_nxt == IDLE);
   end

   assign advance = running && (presc == PRE_LAST);
   assign at_max  = (cnt.m0 == M0_MAX) && (cnt.s1 == S1_MAX) && (cnt.s0 == S0_MAX);

   always_comb begin
      cnt_inc = cnt;
      if (cnt.s0 != S0_MAX) begin
         cnt_inc.s0 = cnt.s0 + 4'd1;
      end else begin
         cnt_inc.s0 = '0;
         if (cnt.s1 != S1_MAX) begin
            cnt_inc.s1 = cnt.s1 + 4'd1;
         end else begin
            cnt_inc.s1 = '0;
            if (cnt.m0 != M0_MAX) cnt_inc.m0 = cnt.m0 + 4'd1;
            else                  cnt_inc.m0 = '0;
         end
      end
   end

   // Lap capture uses cnt (pre-advance) even when a tick lands on the same edge.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         presc  <= '0;
         cnt    <= '0;
         lap_q  <= '0;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         tick_q <= advance;
         wrap_q <= advance && at_max;
         if (zero_all) begin
            presc <= '0;
            cnt   <= '0;
         end else if (running) begin
            if (presc == PRE_LAST) begin
               presc <= '0;
               cnt   <= cnt_inc;
            end else begin
               presc <= presc + 1'b1;
            end
         end
         if (capture)       lap_q <= cnt;
         else if (zero_all) lap_q <= '0;
      end
   end

   assign disp        = split_st ? lap_q : cnt;
   assign bus.disp_m0 = disp.m0;
   assign bus.disp_s1 = disp.s1;
   assign bus.disp_s0 = disp.s0;
   assign bus.running = running;
   assign bus.split   = split_st;
   assign bus.tick    = tick_q;
   assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_SPLIT  = 2;
   localparam int M_PAUSED = 3;
   localparam int DIV      = 4;

   logic clk;
   logic reset;

   stopwatch_ctrl_if sw_if ();

   stopwatch_ctrl #(.TICK_DIV(DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sw_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: count kept as total seconds 0..599
   int m_st, m_total, m_lap, m_presc;
   bit m_tick, m_wrap;
   bit p_ss, p_lap, p_clr;
   int n_ticks, n_wraps;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else             n_pass++;
   endtask

   function automatic logic [31:0] to_digits(input int v);
      return 32'((v / 60) * 256 + ((v % 60) / 10) * 16 + (v % 10));
   endfunction

   function automatic logic [31:0] dut_disp();
      return 32'({sw_if.disp_m0, sw_if.disp_s1, sw_if.disp_s0});
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_total = 0; m_lap = 0; m_presc = 0;
      m_tick = 0; m_wrap = 0;
      p_ss = 0; p_lap = 0; p_clr = 0;
   endtask

   task automatic model_edge(input bit ss, input bit l, input bit c);
      bit e_ss, e_lap, e_clr;
      int old_total;
      e_ss  = ss & !p_ss;
      e_lap = l  & !p_lap;
      e_clr = c  & !p_clr;
      p_ss = ss; p_lap = l; p_clr = c;
      old_total = m_total;
      m_tick = 0;
      m_wrap = 0;
      if (m_st == M_RUN || m_st == M_SPLIT) begin
         m_presc++;
         if (m_presc == DIV) begin
            m_presc = 0;
            m_tick  = 1;
            m_wrap  = (m_total == 599);
            m_total = (m_total + 1) % 600;
         end
      end
      case (m_st)
         M_IDLE:   if (e_ss) m_st = M_RUN;
         M_RUN: begin
            if (e_ss) m_st = M_PAUSED;
            else if (e_lap) begin m_st = M_SPLIT; m_lap = old_total; end
         end
         M_SPLIT: begin
            if (e_ss) m_st = M_PAUSED;
            else if (e_lap) m_st = M_RUN;
         end
         default: begin
            if (e_clr) begin m_st = M_IDLE; m_total = 0; m_presc = 0; m_lap = 0; end
            else if (e_ss) m_st = M_RUN;
         end
      endcase
   endtask

   task automatic check_outputs();
      int shown;
      shown = (m_st == M_SPLIT) ? m_lap : m_total;
      chk("disp",    dut_disp(), to_digits(shown));
      chk("running", 32'(sw_if.running), 32'(m_st == M_RUN || m_st == M_SPLIT));
      chk("split",   32'(sw_if.split),   32'(m_st == M_SPLIT));
      chk("tick",    32'(sw_if.tick),    32'(m_tick));
      chk("wrap",    32'(sw_if.wrap),    32'(m_wrap));
   endtask

   task automatic step(input bit ss, input bit l, input bit c);
      sw_if.start_stop = ss;
      sw_if.lap        = l;
      sw_if.clear      = c;
      @(negedge clk);
      model_edge(ss, l, c);
      #1;
      check_outputs();
      if (sw_if.tick) n_ticks++;
      if (sw_if.wrap) n_wraps++;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0);
   endtask

   // asynchronous reset pulse between edges; outputs must clear immediately
   task automatic do_reset(input bit hold_ss);
      reset = 1'b0;
      #1;
      chk("rst_disp",    dut_disp(), 32'h0);
      chk("rst_running", 32'(sw_if.running), 32'h0);
      chk("rst_split",   32'(sw_if.split),   32'h0);
      chk("rst_tick",    32'(sw_if.tick),    32'h0);
      chk("rst_wrap",    32'(sw_if.wrap),    32'h0);
      model_reset();
      sw_if.start_stop = hold_ss;
      sw_if.lap        = 1'b0;
      sw_if.clear      = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   initial begin
      int edges;
      bit r_ss, r_lap, r_clr;
      reset = 1'b1;
      sw_if.start_stop = 1'b0;
      sw_if.lap        = 1'b0;
      sw_if.clear      = 1'b0;
      #2;
      do_reset(0);

      // start and count to 0:10
      step(1, 0, 0);
      n_ticks = 0;
      idle_steps(40);
      chk("count_0_10", dut_disp(), 32'h010);
      chk("tick_count", 32'(n_ticks), 32'd10);
      chk("run_flag",   32'(sw_if.running), 32'd1);

      // split at 0:05, release 20 edges later at 0:10
      do_reset(0);
      step(1, 0, 0);
      idle_steps(20);
      step(0, 1, 0);
      chk("split_frozen", dut_disp(), 32'h005);
      chk("split_flag",   32'(sw_if.split), 32'd1);
      idle_steps(19);
      chk("split_still",  dut_disp(), 32'h005);
      step(0, 1, 0);
      chk("split_live",   dut_disp(), 32'h010);
      chk("split_off",    32'(sw_if.split), 32'd0);

      // pause leaves prescaler at 2; resume -> advance two edges later
      step(1, 0, 0);
      idle_steps(3);
      step(1, 0, 0);
      edges   = 0;
      n_ticks = 0;
      while (n_ticks == 0 && edges < 10) begin
         step(0, 0, 0);
         edges++;
      end
      chk("resume_phase", 32'(edges), 32'd2);

      // clear while paused, clear ignored while running
      step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 1);
      chk("clear_paused", dut_disp(), 32'h0);
      chk("clear_idle",   32'(sw_if.running), 32'd0);
      step(1, 0, 0);
      idle_steps(5);
      step(0, 0, 1);
      step(0, 0, 0);
      chk("clear_in_run", 32'(sw_if.running), 32'd1);

      // simultaneous events
      step(1, 1, 0);
      chk("ss_lap_run",   32'(sw_if.running), 32'd0);
      chk("ss_lap_split", 32'(sw_if.split),   32'd0);
      step(0, 0, 0);
      step(1, 0, 1);
      chk("clr_ss_disp",  dut_disp(), 32'h0);
      chk("clr_ss_run",   32'(sw_if.running), 32'd0);
      step(0, 0, 0);
      chk("clr_ss_idle",  32'(sw_if.running), 32'd0);

      // wrap 9:59 -> 0:00
      do_reset(0);
      step(1, 0, 0);
      idle_steps(2396);
      chk("preload_959", dut_disp(), 32'h959);
      n_wraps = 0;
      idle_steps(4);
      chk("wrap_to_000", dut_disp(), 32'h0);
      chk("wrap_once",   32'(n_wraps), 32'd1);

      // reset mid-run at 3:27 with start_stop held through release
      do_reset(0);
      step(1, 0, 0);
      idle_steps(828);
      chk("at_3_27", dut_disp(), 32'h327);
      do_reset(1);
      step(1, 0, 0);
      chk("held_ss_start", 32'(sw_if.running), 32'd1);
      step(0, 0, 0);

      // random button traffic
      r_ss = 0; r_lap = 0; r_clr = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9)  == 0) r_ss  = ~r_ss;
         if ($urandom_range(0, 7)  == 0) r_lap = ~r_lap;
         if ($urandom_range(0, 15) == 0) r_clr = ~r_clr;
         step(r_ss, r_lap, r_clr);
         if (i == 1500) do_reset($urandom_range(0, 1) == 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
